// File: rtl/axi4_mgr_pkg.sv
// Shared types and constants for the AXI4 burst manager and its bus interface.
package axi4_mgr_pkg;

    localparam int BOUNDARY_4K  = 4096;
    localparam int AXI_ID_WIDTH = 4;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10
    } axi_burst_t;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } axi_resp_t;

    typedef enum logic [2:0] {
        W_IDLE,
        W_CALC,
        W_AW,
        W_DATA,
        W_B
    } wr_state_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_CALC,
        R_AR,
        R_DATA
    } rd_state_t;

endpackage

// File: rtl/axi4_bus_if.sv
// AXI4 bus bundle with manager and subordinate views.
interface axi4_bus_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int ID_WIDTH   = axi4_mgr_pkg::AXI_ID_WIDTH
);
    logic [ID_WIDTH-1:0]     aw_id;
    logic [ADDR_WIDTH-1:0]   aw_addr;
    logic [7:0]              aw_len;
    logic [2:0]              aw_size;
    logic [1:0]              aw_burst;
    logic                    aw_lock;
    logic [3:0]              aw_cache;
    logic [2:0]              aw_prot;
    logic [3:0]              aw_qos;
    logic                    aw_valid;
    logic                    aw_ready;
    logic [DATA_WIDTH-1:0]   w_data;
    logic [DATA_WIDTH/8-1:0] w_strb;
    logic                    w_last;
    logic                    w_valid;
    logic                    w_ready;
    logic [ID_WIDTH-1:0]     b_id;
    logic [1:0]              b_resp;
    logic                    b_valid;
    logic                    b_ready;
    logic [ID_WIDTH-1:0]     ar_id;
    logic [ADDR_WIDTH-1:0]   ar_addr;
    logic [7:0]              ar_len;
    logic [2:0]              ar_size;
    logic [1:0]              ar_burst;
    logic                    ar_lock;
    logic [3:0]              ar_cache;
    logic [2:0]              ar_prot;
    logic [3:0]              ar_qos;
    logic                    ar_valid;
    logic                    ar_ready;
    logic [ID_WIDTH-1:0]     r_id;
    logic [DATA_WIDTH-1:0]   r_data;
    logic [1:0]              r_resp;
    logic                    r_last;
    logic                    r_valid;
    logic                    r_ready;

    modport Manager (
        output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot, aw_qos, aw_valid,
        input  aw_ready,
        output w_data, w_strb, w_last, w_valid,
        input  w_ready,
        input  b_id, b_resp, b_valid,
        output b_ready,
        output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot, ar_qos, ar_valid,
        input  ar_ready,
        input  r_id, r_data, r_resp, r_last, r_valid,
        output r_ready
    );

    modport Subordinate (
        input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot, aw_qos, aw_valid,
        output aw_ready,
        input  w_data, w_strb, w_last, w_valid,
        output w_ready,
        output b_id, b_resp, b_valid,
        input  b_ready,
        input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot, ar_qos, ar_valid,
        output ar_ready,
        output r_id, r_data, r_resp, r_last, r_valid,
        input  r_ready
    );
endinterface

// File: rtl/axi4_burst_calc.sv
// Beats in the next burst: limited by words remaining, max burst length and the next 4 KiB boundary.
module axi4_burst_calc
    import axi4_mgr_pkg::*;
#(
    parameter int DCW           = 16,
    parameter int MAX_BURST_LEN = 256,
    parameter int SHIFT         = 3
) (
    input  logic [11:0]    addr_i,
    input  logic [DCW-1:0] remain_i,
    output logic [8:0]     len_o
);
    logic [12:0] to_4k_beats;
    logic [8:0]  cap;

    always_comb begin
        to_4k_beats = (13'(BOUNDARY_4K) - {1'b0, addr_i}) >> SHIFT;
        cap         = (to_4k_beats < 13'(MAX_BURST_LEN)) ? to_4k_beats[8:0] : 9'(MAX_BURST_LEN);
        len_o       = (32'(remain_i) < 32'(cap)) ? remain_i[8:0] : cap;
    end
endmodule

// File: rtl/axi4_burst_mgr.sv
// Block mover between write/read streams and AXI memory using INCR bursts, split at
// MAX_BURST_LEN beats and 4 KiB boundaries. Read and write FSMs run independently.
module axi4_burst_mgr
    import axi4_mgr_pkg::*;
#(
    parameter int AXI_ADDR_WIDTH   = 32,
    parameter int AXI_DATA_WIDTH   = 64,
    parameter int DATA_COUNT_WIDTH = 16,
    parameter int MAX_BURST_LEN    = 256,
    parameter int AXI_ID           = 0
) (
    input  logic                        clk_i,
    input  logic                        rstn_i,
    input  logic                        wr_req_i,
    input  logic [AXI_ADDR_WIDTH-1:0]   wr_addr_i,
    input  logic [DATA_COUNT_WIDTH-1:0] wr_count_i,
    input  logic [AXI_DATA_WIDTH-1:0]   wr_data_i,
    input  logic                        wr_valid_i,
    output logic                        wr_ready_o,
    output logic                        wr_busy_o,
    output logic                        wr_done_o,
    output logic [1:0]                  wr_err_o,
    input  logic                        rd_req_i,
    input  logic [AXI_ADDR_WIDTH-1:0]   rd_addr_i,
    input  logic [DATA_COUNT_WIDTH-1:0] rd_count_i,
    output logic [AXI_DATA_WIDTH-1:0]   rd_data_o,
    output logic                        rd_valid_o,
    input  logic                        rd_ready_i,
    output logic                        rd_busy_o,
    output logic                        rd_done_o,
    output logic [1:0]                  rd_err_o,
    axi4_bus_if.Manager                 axi_mgr_if
);
    localparam int AW    = AXI_ADDR_WIDTH;
    localparam int DCW   = DATA_COUNT_WIDTH;
    localparam int BYTES = AXI_DATA_WIDTH / 8;
    localparam int SHIFT = $clog2(BYTES);
    localparam logic [AW-1:0] ALIGN_MASK = ~AW'(BYTES - 1);

    wr_state_t      w_state_q, w_state_d;
    logic [AW-1:0]  w_addr_q, w_addr_d;
    logic [DCW-1:0] w_remain_q, w_remain_d;
    logic [8:0]     w_len_q, w_len_d, w_beat_q, w_beat_d, w_len_calc;
    logic           w_done_q, w_done_d, w_last;
    logic [1:0]     w_err_q, w_err_d;

    rd_state_t      r_state_q, r_state_d;
    logic [AW-1:0]  r_addr_q, r_addr_d;
    logic [DCW-1:0] r_remain_q, r_remain_d, r_remain_after;
    logic [8:0]     r_len_q, r_len_d, r_beat_q, r_beat_d, r_len_calc;
    logic           r_done_q, r_done_d, r_last_beat;
    logic [1:0]     r_err_q, r_err_d;

    axi4_burst_calc #(.DCW(DCW), .MAX_BURST_LEN(MAX_BURST_LEN), .SHIFT(SHIFT)) u_wr_calc (
        .addr_i(w_addr_q[11:0]), .remain_i(w_remain_q), .len_o(w_len_calc)
    );
    axi4_burst_calc #(.DCW(DCW), .MAX_BURST_LEN(MAX_BURST_LEN), .SHIFT(SHIFT)) u_rd_calc (
        .addr_i(r_addr_q[11:0]), .remain_i(r_remain_q), .len_o(r_len_calc)
    );

    assign w_last = (w_beat_q == w_len_q - 9'd1);

    always_comb begin
        w_state_d  = w_state_q;
        w_addr_d   = w_addr_q;
        w_remain_d = w_remain_q;
        w_len_d    = w_len_q;
        w_beat_d   = w_beat_q;
        w_err_d    = w_err_q;
        w_done_d   = 1'b0;
        case (w_state_q)
            W_IDLE: if (wr_req_i) begin
                w_err_d = RESP_OKAY;
                if (wr_count_i != '0) begin
                    w_addr_d   = wr_addr_i & ALIGN_MASK;
                    w_remain_d = wr_count_i;
                    w_state_d  = W_CALC;
                end else begin
                    w_done_d = 1'b1;
                end
            end
            W_CALC: begin
                w_len_d   = w_len_calc;
                w_beat_d  = '0;
                w_state_d = W_AW;
            end
            W_AW: if (axi_mgr_if.aw_ready) w_state_d = W_DATA;
            W_DATA: if (wr_valid_i && axi_mgr_if.w_ready) begin
                w_beat_d = w_beat_q + 9'd1;
                if (w_last) begin
                    w_addr_d   = w_addr_q + (AW'(w_len_q) << SHIFT);
                    w_remain_d = w_remain_q - DCW'(w_len_q);
                    w_state_d  = W_B;
                end
            end
            W_B: if (axi_mgr_if.b_valid) begin
                if (axi_mgr_if.b_resp != RESP_OKAY) w_err_d = axi_mgr_if.b_resp;
                if (w_remain_q != '0) begin
                    w_state_d = W_CALC;
                end else begin
                    w_state_d = W_IDLE;
                    w_done_d  = 1'b1;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    assign r_last_beat    = (r_beat_q == r_len_q - 9'd1);
    assign r_remain_after = r_remain_q - DCW'(r_len_q);

    always_comb begin
        r_state_d  = r_state_q;
        r_addr_d   = r_addr_q;
        r_remain_d = r_remain_q;
        r_len_d    = r_len_q;
        r_beat_d   = r_beat_q;
        r_err_d    = r_err_q;
        r_done_d   = 1'b0;
        case (r_state_q)
            R_IDLE: if (rd_req_i) begin
                r_err_d = RESP_OKAY;
                if (rd_count_i != '0) begin
                    r_addr_d   = rd_addr_i & ALIGN_MASK;
                    r_remain_d = rd_count_i;
                    r_state_d  = R_CALC;
                end else begin
                    r_done_d = 1'b1;
                end
            end
            R_CALC: begin
                r_len_d   = r_len_calc;
                r_beat_d  = '0;
                r_state_d = R_AR;
            end
            R_AR: if (axi_mgr_if.ar_ready) r_state_d = R_DATA;
            R_DATA: if (axi_mgr_if.r_valid && rd_ready_i) begin
                if (axi_mgr_if.r_resp != RESP_OKAY) r_err_d = axi_mgr_if.r_resp;
                // A premature r_last is flagged but the burst still runs to its own length.
                if (axi_mgr_if.r_last && !r_last_beat) r_err_d = RESP_SLVERR;
                r_beat_d = r_beat_q + 9'd1;
                if (r_last_beat) begin
                    r_addr_d   = r_addr_q + (AW'(r_len_q) << SHIFT);
                    r_remain_d = r_remain_after;
                    if (r_remain_after != '0) begin
                        r_state_d = R_CALC;
                    end else begin
                        r_state_d = R_IDLE;
                        r_done_d  = 1'b1;
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            w_state_q  <= W_IDLE;
            w_addr_q   <= '0;
            w_remain_q <= '0;
            w_len_q    <= '0;
            w_beat_q   <= '0;
            w_done_q   <= 1'b0;
            w_err_q    <= '0;
            r_state_q  <= R_IDLE;
            r_addr_q   <= '0;
            r_remain_q <= '0;
            r_len_q    <= '0;
            r_beat_q   <= '0;
            r_done_q   <= 1'b0;
            r_err_q    <= '0;
        end else begin
            w_state_q  <= w_state_d;
            w_addr_q   <= w_addr_d;
            w_remain_q <= w_remain_d;
            w_len_q    <= w_len_d;
            w_beat_q   <= w_beat_d;
            w_done_q   <= w_done_d;
            w_err_q    <= w_err_d;
            r_state_q  <= r_state_d;
            r_addr_q   <= r_addr_d;
            r_remain_q <= r_remain_d;
            r_len_q    <= r_len_d;
            r_beat_q   <= r_beat_d;
            r_done_q   <= r_done_d;
            r_err_q    <= r_err_d;
        end
    end

    assign wr_ready_o = (w_state_q == W_DATA) && axi_mgr_if.w_ready;
    assign wr_busy_o  = (w_state_q != W_IDLE);
    assign wr_done_o  = w_done_q;
    assign wr_err_o   = w_err_q;
    assign rd_data_o  = (r_state_q == R_DATA) ? axi_mgr_if.r_data : '0;
    assign rd_valid_o = (r_state_q == R_DATA) && axi_mgr_if.r_valid;
    assign rd_busy_o  = (r_state_q != R_IDLE);
    assign rd_done_o  = r_done_q;
    assign rd_err_o   = r_err_q;

    assign axi_mgr_if.aw_id    = AXI_ID_WIDTH'(AXI_ID);
    assign axi_mgr_if.aw_addr  = w_addr_q;
    assign axi_mgr_if.aw_len   = 8'(w_len_q - 9'd1);
    assign axi_mgr_if.aw_size  = 3'(SHIFT);
    assign axi_mgr_if.aw_burst = BURST_INCR;
    assign axi_mgr_if.aw_lock  = 1'b0;
    assign axi_mgr_if.aw_cache = '0;
    assign axi_mgr_if.aw_prot  = '0;
    assign axi_mgr_if.aw_qos   = '0;
    assign axi_mgr_if.aw_valid = (w_state_q == W_AW);
    assign axi_mgr_if.w_data   = wr_data_i;
    assign axi_mgr_if.w_strb   = '1;
    assign axi_mgr_if.w_last   = (w_state_q == W_DATA) && w_last;
    assign axi_mgr_if.w_valid  = (w_state_q == W_DATA) && wr_valid_i;
    assign axi_mgr_if.b_ready  = (w_state_q == W_B);

    assign axi_mgr_if.ar_id    = AXI_ID_WIDTH'(AXI_ID);
    assign axi_mgr_if.ar_addr  = r_addr_q;
    assign axi_mgr_if.ar_len   = 8'(r_len_q - 9'd1);
    assign axi_mgr_if.ar_size  = 3'(SHIFT);
    assign axi_mgr_if.ar_burst = BURST_INCR;
    assign axi_mgr_if.ar_lock  = 1'b0;
    assign axi_mgr_if.ar_cache = '0;
    assign axi_mgr_if.ar_prot  = '0;
    assign axi_mgr_if.ar_qos   = '0;
    assign axi_mgr_if.ar_valid = (r_state_q == R_AR);
    assign axi_mgr_if.r_ready  = (r_state_q == R_DATA) && rd_ready_i;
endmodule
